// File: rtl/btn_reg_if.sv
// Read-only register port between the CPU peripheral bus and btn_reg.
// The bus side drives the strobe and address; the peripheral returns registered read data.
interface btn_reg_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  read_enable;
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           data_out;

    modport master (output read_enable, output address, input data_out);
    modport slave  (input read_enable, input address, output data_out);
endinterface

// File: rtl/btn_reg.sv
// Two active-low push buttons: sync, press-edge detect, clear-on-read event flags, live state.
// Optional debouncer on the synchronised inputs is enabled with BTN_DEBOUNCE_EN.
module btn_reg #(
    parameter int ADDR_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     btn1,
    input  logic     btn2,
    btn_reg_if.slave bus
);
    // Bit 0 is button 1, bit 1 is button 2 throughout.
    logic [1:0]  r_meta;
    logic [1:0]  r_sync;
    logic [1:0]  r_prev;
    logic [1:0]  r_flag;
    logic [31:0] r_data;
    logic [1:0]  w_state;
    logic [1:0]  w_press;
    logic [1:0]  w_clr;
    logic [31:0] w_rdata;

    if (DEBOUNCE_CYCLES < 1) begin : g_cfg_err
        $error("btn_reg: DEBOUNCE_CYCLES must be at least 1");
    end

    // Preset to released so reset deassertion never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 2'b11;
            r_sync <= 2'b11;
        end else begin
            r_meta <= {btn2, btn1};
            r_sync <= r_meta;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_db;
    logic [CW-1:0] r_cnt [2];

    // Down-counter reloads on every agreeing sample; terminal count commits the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db <= 2'b11;
            for (int i = 0; i < 2; i++) r_cnt[i] <= CNT_LOAD;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync[i] == r_db[i]) begin
                    r_cnt[i] <= CNT_LOAD;
                end else if (r_cnt[i] == '0) begin
                    r_db[i]  <= r_sync[i];
                    r_cnt[i] <= CNT_LOAD;
                end else begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    assign w_state = r_db;
`else
    assign w_state = r_sync;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_prev <= 2'b11;
        else        r_prev <= w_state;
    end

    assign w_press  = r_prev & ~w_state;
    assign w_clr[0] = bus.read_enable && (bus.address == ADDR_WIDTH'(0));
    assign w_clr[1] = bus.read_enable && (bus.address == ADDR_WIDTH'(1));

    always_comb begin
        w_rdata = 32'd0;
        case (bus.address)
            ADDR_WIDTH'(0): w_rdata = {31'd0, r_flag[0]};
            ADDR_WIDTH'(1): w_rdata = {31'd0, r_flag[1]};
            ADDR_WIDTH'(2): w_rdata = {30'd0, ~w_state[1], ~w_state[0]};
            default:        w_rdata = 32'd0;
        endcase
    end

    // A press landing on the same edge as its clearing read wins, so the event survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= 2'b00;
            r_data <= 32'd0;
        end else begin
            r_flag <= w_press | (r_flag & ~w_clr);
            if (bus.read_enable) r_data <= w_rdata;
        end
    end

    assign bus.data_out = r_data;
endmodule

// File: tb/tb_btn_reg.sv
// Directed bench for btn_reg: expected read data is queued when a read is issued
// and compared against data_out on the following falling edge.
module tb_btn_reg;
    localparam int AW = 8;

    logic clk;
    logic rst_n;
    logic btn1;
    logic btn2;

    btn_reg_if #(.ADDR_WIDTH(AW)) bus ();

    btn_reg #(.ADDR_WIDTH(AW), .DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn1  (btn1),
        .btn2  (btn2),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic compare(input string tag);
        logic [31:0] exp;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed %h, no expected value queued", tag, bus.data_out);
        end else begin
            exp = exp_q.pop_front();
            n_checks++;
            assert (bus.data_out === exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, bus.data_out, exp);
            end
        end
    endtask

    // Called at a falling edge; the read is captured on the next rising edge.
    task automatic rd(input logic [AW-1:0] a, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        bus.read_enable = 1'b1;
        bus.address     = a;
        @(negedge clk);
        bus.read_enable = 1'b0;
        compare(tag);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n           = 1'b0;
        btn1            = 1'b1;
        btn2            = 1'b1;
        bus.read_enable = 1'b0;
        bus.address     = '0;
        idle(3);
        exp_q.push_back(32'd0);
        compare("reset_data_out");
        rst_n = 1'b1;
        idle(3);

        rd(8'd0, 32'd0, "post_reset_flag1");
        rd(8'd1, 32'd0, "post_reset_flag2");
        rd(8'd2, 32'd0, "post_reset_live");

`ifndef BTN_DEBOUNCE_EN
        // 2-clock press of btn1
        btn1 = 1'b0;
        idle(2);
        btn1 = 1'b1;
        idle(1);
        rd(8'd0, 32'd1, "short_press_flag1");
        rd(8'd0, 32'd0, "flag1_cleared");
        rd(8'd1, 32'd0, "flag2_untouched");

        // btn2 held: single event, live state shows pressed
        btn2 = 1'b0;
        idle(20);
        rd(8'd1, 32'd1, "held_flag2");
        rd(8'd1, 32'd0, "held_flag2_once");
        rd(8'd2, 32'd2, "held_live");
        btn2 = 1'b1;
        idle(4);
        rd(8'd1, 32'd0, "release_no_event");
        rd(8'd2, 32'd0, "released_live");

        // press event lands on the same edge as a clearing read
        btn1 = 1'b0;
        idle(2);
        rd(8'd0, 32'd0, "set_clear_collision_old");
        btn1 = 1'b1;
        rd(8'd0, 32'd1, "set_wins");
        rd(8'd0, 32'd0, "set_wins_cleared");
        idle(3);

        // unmapped addresses
        rd(8'd5, 32'd0, "unmapped_5");
        rd(8'hFF, 32'd0, "unmapped_ff");
        rd(8'd3, 32'd0, "unmapped_3");

        // no read strobe: data_out holds, flag not cleared
        btn1 = 1'b0;
        idle(2);
        btn1 = 1'b1;
        btn2 = 1'b0;
        idle(4);
        rd(8'd2, 32'd2, "live_btn2");
        btn2 = 1'b1;
        bus.address = 8'd0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'd2);
            @(negedge clk);
            compare("hold_no_strobe");
        end
        rd(8'd0, 32'd1, "flag1_kept");
        rd(8'd1, 32'd1, "flag2_kept");
        rd(8'd0, 32'd0, "flag1_after_clear");

        // reset mid-operation clears pending events and read data
        btn1 = 1'b0;
        idle(2);
        btn1 = 1'b1;
        btn2 = 1'b0;
        idle(4);
        rd(8'd2, 32'd2, "pre_reset_live");
        #2;
        rst_n = 1'b0;
        btn2  = 1'b1;
        #1;
        exp_q.push_back(32'd0);
        compare("async_reset_data_out");
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        rd(8'd0, 32'd0, "reset_cleared_flag1");
        rd(8'd1, 32'd0, "reset_cleared_flag2");
`else
        // glitch shorter than the debounce window is ignored
        btn1 = 1'b0;
        idle(2);
        btn1 = 1'b1;
        idle(12);
        rd(8'd0, 32'd0, "db_glitch_ignored");
        rd(8'd2, 32'd0, "db_glitch_live");

        // long press registers once
        btn1 = 1'b0;
        idle(10);
        rd(8'd2, 32'd1, "db_live_pressed");
        btn1 = 1'b1;
        idle(12);
        rd(8'd0, 32'd1, "db_long_press");
        rd(8'd0, 32'd0, "db_flag_cleared");
        rd(8'd2, 32'd0, "db_released_live");

        btn2 = 1'b0;
        idle(20);
        rd(8'd1, 32'd1, "db_held_flag2");
        rd(8'd1, 32'd0, "db_held_once");
        btn2 = 1'b1;
        idle(12);
        rd(8'd1, 32'd0, "db_release_no_event");
        rd(8'hFF, 32'd0, "db_unmapped");
`endif

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d leftover entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
